// File: rtl/dmem_io_ctrl.sv
// rtl/dmem_io_ctrl.sv - data memory and memory-mapped I/O controller
//
// Word-addressed RAM plus a small memory-mapped I/O block: 7-segment
// display register, synchronized switch status, sticky switch rising-edge
// flags (cleared by reading), and a free-running prescaled timer.
//
// Ports:
//   clock      - single clock, all state updates on its rising edge
//   reset      - asynchronous, active-low reset (RAM contents are kept)
//   dmemaddr   - 16-bit word address
//   dmemwdata  - write data, DW bits
//   dmemwrite  - write enable
//   dmemread   - read enable; dmemrdata is combinational from current state
//   io_sw      - asynchronous switch inputs, NSW bits
//   dmemrdata  - read data, 0 when not reading or address unmapped
//   io_display - 7-segment drive, mirrors the DISP register

module dmem_io_ctrl #(
  parameter int DW       = 16,
  parameter int DEPTH    = 128,
  parameter int NSW      = 2,
  parameter int PRESCALE = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [15:0]    dmemaddr,
  input  logic [DW-1:0]  dmemwdata,
  input  logic           dmemwrite,
  input  logic           dmemread,
  input  logic [NSW-1:0] io_sw,
  output logic [DW-1:0]  dmemrdata,
  output logic [6:0]     io_display
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [16:0]   DEPTH_EXT = 17'(DEPTH);

  localparam logic [15:0] ADDR_DISP   = 16'hFFF0;
  localparam logic [15:0] ADDR_SWSTAT = 16'hFFF2;
  localparam logic [15:0] ADDR_SWEDGE = 16'hFFF4;
  localparam logic [15:0] ADDR_TIMER  = 16'hFFF6;
  localparam logic [15:0] ADDR_PRESC  = 16'hFFF8;

  logic [DW-1:0]  mem [DEPTH];
  logic [6:0]     disp;
  logic [NSW-1:0] sw_s1, sw_s2, sw_s3;
  logic [NSW-1:0] sw_edge;
  logic [DW-1:0]  timer;
  logic [PW-1:0]  presc;

  logic           ram_sel;
  logic [AW-1:0]  ram_idx;
  logic           disp_wr;
  logic           timer_wr;
  logic           swedge_rd;
  logic [NSW-1:0] sw_rise;

  assign ram_sel   = ({1'b0, dmemaddr} < DEPTH_EXT);
  assign ram_idx   = dmemaddr[AW-1:0];
  assign disp_wr   = dmemwrite && (dmemaddr == ADDR_DISP);
  assign timer_wr  = dmemwrite && (dmemaddr == ADDR_TIMER);
  assign swedge_rd = dmemread && (dmemaddr == ADDR_SWEDGE);
  assign sw_rise   = sw_s2 & ~sw_s3;

  assign io_display = disp;

  // RAM has no reset so its contents survive reset; writes are still
  // blocked while reset is held.
  always_ff @(posedge clock) begin
    if (reset && dmemwrite && ram_sel) begin
      mem[ram_idx] <= dmemwdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp    <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      sw_s3   <= '0;
      sw_edge <= '0;
      timer   <= '0;
      presc   <= '0;
    end else begin
      if (disp_wr) begin
        disp <= dmemwdata[6:0];
      end

      sw_s1 <= io_sw;
      sw_s2 <= sw_s1;
      sw_s3 <= sw_s2;

      // OR-ing the new rises after the clear makes a coincident edge survive.
      sw_edge <= (swedge_rd ? '0 : sw_edge) | sw_rise;

      // A timer load restarts the prescale period and beats any increment.
      if (timer_wr) begin
        timer <= dmemwdata;
        presc <= '0;
      end else if (presc == PRESC_MAX) begin
        timer <= timer + 1'b1;
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Reads see pre-edge state, so read-during-write returns the old value.
  always_comb begin
    dmemrdata = '0;
    if (dmemread) begin
      if (ram_sel) begin
        dmemrdata = mem[ram_idx];
      end else begin
        case (dmemaddr)
          ADDR_DISP:   dmemrdata = DW'(disp);
          ADDR_SWSTAT: dmemrdata = DW'(sw_s2);
          ADDR_SWEDGE: dmemrdata = DW'(sw_edge);
          ADDR_TIMER:  dmemrdata = timer;
          ADDR_PRESC:  dmemrdata = DW'(presc);
          default:     dmemrdata = '0;
        endcase
      end
    end
  end

endmodule

// File: doc/dmem_io_ctrl.md
DMEM_IO_CTRL -- requirements
Module: dmem_io_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 128: RAM depth in words, power of two, 2..4096.
REQ-003 SHALL have parameter NSW, default 2: number of switch inputs, 1..DW.
REQ-004 SHALL have parameter PRESCALE, default 4: clocks per timer increment, at least 1.
REQ-005 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port dmemaddr, input, 16 bits: word address.
REQ-008 SHALL have port dmemwdata, input, DW bits: write data.
REQ-009 SHALL have port dmemwrite, input, 1 bit: write enable.
REQ-010 SHALL have port dmemread, input, 1 bit: read enable.
REQ-011 SHALL have port io_sw, input, NSW bits: asynchronous switch inputs.
REQ-012 SHALL have port dmemrdata, output, DW bits: read data.
REQ-013 SHALL have port io_display, output, 7 bits: 7-segment drive.

Function
REQ-014 SHALL decode the memory map as follows:
- addresses below DEPTH: RAM;
- 16'hFFF0 DISP, read/write;
- 16'hFFF2 SWSTAT, read-only;
- 16'hFFF4 SWEDGE, read-clear;
- 16'hFFF6 TIMER, read/write;
- 16'hFFF8 PRESC, read-only current prescaler count;
- all other addresses unmapped.
REQ-015 SHALL drive dmemrdata combinationally (zero-latency read) when dmemread=1; SHALL drive 0 when dmemread=0 or the address is unmapped.
REQ-016 SHALL perform RAM writes on the rising edge when dmemwrite=1, indexing RAM with dmemaddr[log2(DEPTH)-1:0].
REQ-017 SHALL ignore writes to unmapped, SWSTAT, SWEDGE and PRESC addresses.
REQ-018 SHALL load DISP from dmemwdata[6:0] on a write to DISP; io_display SHALL equal DISP; DISP bits above bit 6 SHALL read as 0.
REQ-019 SHALL pass each io_sw bit through a 2-flop synchronizer; SWSTAT SHALL equal the second-stage value, zero-extended to DW.
REQ-020 SHALL set SWEDGE bit i when synchronized bit i transitions 0->1 (detected with a third delay flop).
- SWEDGE bits SHALL remain set (sticky) until cleared.
REQ-021 SHALL clear SWEDGE to 0 on the rising edge when dmemread=1 at the SWEDGE address.
- If a new rising edge arrives in the same cycle, that bit SHALL end set (set wins over clear).
REQ-022 SHALL implement the prescaler as a counter 0..PRESCALE-1.
- At PRESCALE-1 it SHALL wrap to 0 and increment TIMER by 1, modulo 2^DW (0xFFFF wraps to 0).
REQ-023 On a TIMER write, SHALL load TIMER with dmemwdata and reset the prescaler to 0 in that cycle.
- The write SHALL take priority over any increment in the same cycle.
REQ-024 SHALL treat dmemread and dmemwrite both asserted as a write, with dmemrdata showing the pre-write value.
REQ-025 SHALL apply RAM read-during-write as old data combinationally; the new data SHALL be visible from the next cycle.

Reset
REQ-026 SHALL, when reset=0, asynchronously clear DISP, io_display, the synchronizer and delay flops, SWEDGE, TIMER and the prescaler to 0.
REQ-027 SHALL not reset RAM contents; RAM SHALL retain its data across reset.
REQ-028 SHALL ignore writes while reset=0, while dmemrdata still follows REQ-015.
REQ-029 Reset asserted mid-count SHALL leave TIMER=0 and prescaler=0, and counting SHALL resume on the first clock edge after reset release.

Verification
REQ-030 Write 16'h1234 to address 5, then read address 5 -> dmemrdata=16'h1234; read 16'h0200 -> 0; write to 16'h0200 leaves RAM unchanged.
REQ-031 Write 16'hFF49 to DISP -> io_display=7'h49; read DISP -> 16'h0049.
REQ-032 io_sw 2'b00->2'b10 -> SWSTAT=2 after 2 clocks and SWEDGE=2 after 3 clocks; read SWEDGE -> returns 2, then 0 next cycle; an edge coincident with the clear leaves the bit set.
REQ-033 PRESCALE=4 from reset -> TIMER=1 after 4 clocks; write 16'hFFFF -> TIMER=0 four clocks later; a write in the increment cycle loads the written value.
REQ-034 Assert reset mid-count with TIMER=7 and DISP=7'h3F -> both 0 immediately, without a clock; RAM word 5 still reads 16'h1234.
REQ-035 Read and write to address 3 in the same cycle (old 16'hAAAA, new 16'h5555) -> dmemrdata=16'hAAAA that cycle, then 16'h5555.
